// File: rtl/spi_slave_sync.sv
// SPI slave running entirely in the clk domain: pins are synchronised and edge-detected.
// Optional SPI_SLAVE_LOOPBACK_EN: the underrun fill word is the last received word instead of zero.
module spi_slave_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  input  logic             spi_cs_n,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             busy
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH);
  localparam logic             SCLK_IDLE = 1'(CPOL);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   rise_c, fall_c, lead_c, trail_c, sample_c, shift_c, cs_fall_c;
  logic                   sample_q, shift_q, mosi_q;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       tx_buf, tx_buf_nxt;
  logic                   tx_ready_nxt;
  logic [WIDTH-1:0]       tx_sh, tx_sh_nxt;
  logic [WIDTH-2:0]       rx_sh, rx_sh_nxt;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic                   miso_nxt;
  logic [WIDTH-1:0]       rx_data_nxt;
  logic                   rx_valid_nxt, rx_overrun_nxt, busy_nxt;
  logic                   load;
  logic [WIDTH-1:0]       rx_word, fill_word;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge classification from the last two synchronised spi_clk samples
  assign rise_c    = sclk_s & ~sclk_prev;
  assign fall_c    = ~sclk_s & sclk_prev;
  assign lead_c    = (CPOL == 0) ? rise_c : fall_c;
  assign trail_c   = (CPOL == 0) ? fall_c : rise_c;
  assign sample_c  = (CPHA == 0) ? lead_c : trail_c;
  assign shift_c   = (CPHA == 0) ? trail_c : lead_c;
  assign cs_fall_c = cs_prev & ~cs_s;

  // Synchronisers reset to idle pin levels so no edge appears after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= SCLK_IDLE;
      cs_prev   <= 1'b1;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      sample_q  <= sample_c;
      shift_q   <= shift_c;
      mosi_q    <= mosi_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_buf      <= '0;
      tx_ready    <= 1'b1;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      tx_buf      <= tx_buf_nxt;
      tx_ready    <= tx_ready_nxt;
      tx_sh       <= tx_sh_nxt;
      rx_sh       <= rx_sh_nxt;
      bit_cnt     <= bit_cnt_nxt;
      spi_miso    <= miso_nxt;
      spi_miso_oe <= ~cs_s;
      rx_data     <= rx_data_nxt;
      rx_valid    <= rx_valid_nxt;
      rx_overrun  <= rx_overrun_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    tx_buf_nxt     = tx_buf;
    tx_ready_nxt   = tx_ready;
    tx_sh_nxt      = tx_sh;
    rx_sh_nxt      = rx_sh;
    bit_cnt_nxt    = bit_cnt;
    miso_nxt       = spi_miso;
    rx_data_nxt    = rx_data;
    rx_valid_nxt   = rx_valid;
    rx_overrun_nxt = 1'b0;
    busy_nxt       = busy;
    load           = 1'b0;
    rx_word        = {rx_sh, mosi_q};
`ifdef SPI_SLAVE_LOOPBACK_EN
    // A reload at word completion echoes the word completing in this very cycle
    fill_word      = (state == SHIFT) ? rx_word : rx_data;
`else
    fill_word      = '0;
`endif

    if (tx_valid && tx_ready) begin
      tx_buf_nxt   = tx_data;
      tx_ready_nxt = 1'b0;
    end
    if (rx_valid && rx_ready) begin
      rx_valid_nxt = 1'b0;
    end

    if (cs_s) begin
      state_nxt   = IDLE;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_fall_c) state_nxt = LOAD;
        end
        LOAD: begin
          load      = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
        SHIFT: begin
          // A shift edge at bit count 0 belongs to a freshly loaded word and only holds the MSB
          if (shift_q && (bit_cnt != '0)) begin
            tx_sh_nxt = {tx_sh[WIDTH-2:0], 1'b0};
            miso_nxt  = tx_sh[WIDTH-2];
          end
          if (sample_q) begin
            rx_sh_nxt = rx_word[WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_nxt    = '0;
              load           = 1'b1;
              rx_data_nxt    = rx_word;
              rx_valid_nxt   = 1'b1;
              rx_overrun_nxt = rx_valid && !rx_ready;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (load) begin
      if (!tx_ready) begin
        tx_sh_nxt    = tx_buf;
        tx_ready_nxt = 1'b1;
      end else begin
        tx_sh_nxt = fill_word;
      end
      miso_nxt = tx_sh_nxt[WIDTH-1];
    end
  end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Parametrised SPI slave, successor to the first-generation spi_clk-clocked loopback slave.
- Runs entirely in the system clk domain: SPI pins are synchronised and edge-detected, so no logic is clocked by spi_clk.
- Supports all four CPOL/CPHA modes, configurable word width and back-to-back words within one chip-select.
- Provides valid/ready handshakes toward user logic on the ice4pi board (LEDs, pmod, test cores).

Parameters:
- WIDTH, 8, bits per SPI word (2..32).
- CPOL, 0, idle level of spi_clk.
- CPHA, 1, 0 = sample on leading edge; 1 = sample on trailing edge.
- SYNC_STAGES, 2, synchroniser flops on spi_clk, spi_mosi and spi_cs_n (2..3).

Ports:
- clk  in  1  system clock; must be >= 4x spi_clk frequency.
- rst_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  SPI serial clock from master.
- spi_mosi  in  1  master-out data.
- spi_cs_n  in  1  active-low chip select.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  high while the synchronised cs_n is low.
- tx_data  in  WIDTH  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  single-entry tx buffer empty.
- rx_data  out  WIDTH  last received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data.
- rx_overrun  out  1  one-cycle strobe.
- busy  out  1  word in progress.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, busy=0. Shifters and bit counter also reset to 0.
- Sync: each SPI input passes through SYNC_STAGES flops. Edges are detected by comparing the last two synced spi_clk values.
- Edge mapping:
  - leading = rising if CPOL=0, falling if CPOL=1.
  - sample edge = leading if CPHA=0, trailing if CPHA=1.
  - shift edge = the other edge.
- Tx buffer: single entry. Accepted on tx_valid&&tx_ready. tx_ready=0 until the word is moved into the tx shifter.
- FSM IDLE:
  - Entered on reset, or whenever synced cs_n=1.
  - busy=0, bit counter=0.
  - On synced cs_n falling -> LOAD.
- FSM LOAD (1 cycle):
  - tx shifter <= tx buffer if full (buffer freed, tx_ready=1 next cycle), else underrun fill word.
  - spi_miso = shifter MSB.
  - Go to SHIFT with busy=1.
- FSM SHIFT:
  - On sample edge: rx shifter <= {rx[WIDTH-2:0], mosi}; bit counter++.
  - On shift edge: tx shifter shifts left and spi_miso = new MSB. Exception: with CPHA=1 the first shift edge of each word only holds the MSB (no shift).
- Word completion, on the WIDTH-th sample edge:
  - rx_data <= completed word; rx_valid=1 from the next cycle.
  - Bit counter wraps to 0 and the tx shifter reloads per the LOAD rule in the same cycle, so consecutive words need no cs_n toggle.
- Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the final sample edge at the pin.
- rx handshake: rx_valid holds until rx_valid&&rx_ready, then clears next cycle.
- Overrun: a completion while rx_valid=1 and rx_ready=0 overwrites rx_data, keeps rx_valid=1 and pulses rx_overrun for 1 cycle. A completion in the same cycle as a consume makes rx_valid stay 1 with the new data and gives no overrun.
- cs_n deasserted mid-word: abort to IDLE. The partial rx word is discarded (no rx_valid). A tx word already moved into the shifter is lost. The tx buffer is unaffected.
- rst_n asserted mid-transfer: all state returns to reset values immediately. The synchroniser flops reset to the idle levels (spi_clk=CPOL, cs_n=1), so no spurious edge is seen after release.
- Bit order: MSB first in both directions.

Optional Feature:
- Macro: SPI_SLAVE_LOOPBACK_EN.
- Defined: the underrun fill word is the last completed rx word (0 after reset), giving master echo when the user logic supplies nothing.
- Undefined: the underrun fill word is all zeros.

Test Plan:
- Mode 1, WIDTH=8: preload tx 0xA5, master sends 0x3C -> master reads 0xA5; rx_data=0x3C, rx_valid=1; tx_ready returns to 1 after LOAD.
- Modes 0, 2 and 3: master sends 0x81 with tx 0x7E in each -> master reads 0x7E, rx_data=0x81 every mode.
- Three back-to-back words 0x11, 0x22, 0x33 under one cs_n:
  - rx_ready held low -> rx_overrun pulses twice, final rx_data=0x33.
  - rx_ready held high -> three rx_valid handshakes, no overrun.
- cs_n raised after 5 bits, then a full word 0x55 -> single rx_valid with 0x55; no output for the aborted word.
- Empty tx buffer, master sends 0x9C then 0x00 -> second word the master reads is 0x9C if SPI_SLAVE_LOOPBACK_EN is defined, else 0x00.
- rst_n pulsed low mid-word -> all outputs at reset values. The next full transfer of 0xF0 completes correctly.
